// File: rtl/sync_tp_ram_be.sv
// Synchronous two-port RAM with byte-lane write enables, selectable read-during-write
// behaviour, an optional 0..3 stage output pipeline and a read-valid strobe.

module sync_tp_ram_be_chk #(
  parameter int unsigned ADDR_WIDTH = 10,
  parameter int unsigned DATA_DEPTH = 1024,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned BYTE_WIDTH = 8,
  parameter int unsigned OUT_REGS   = 0
);
  // Elaboration-time parameter sanity checks.
  if ((2 ** ADDR_WIDTH) < DATA_DEPTH) begin : g_depth_chk
    $error("sync_tp_ram_be: DATA_DEPTH exceeds 2**ADDR_WIDTH");
  end
  if ((DATA_WIDTH % BYTE_WIDTH) != 0) begin : g_width_chk
    $error("sync_tp_ram_be: DATA_WIDTH not a multiple of BYTE_WIDTH");
  end
  if (OUT_REGS > 3) begin : g_oreg_chk
    $error("sync_tp_ram_be: OUT_REGS must be 0..3");
  end
endmodule

module sync_tp_ram_be #(
  parameter int unsigned ADDR_WIDTH = 10,
  parameter int unsigned DATA_DEPTH = 1024,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned BYTE_WIDTH = 8,
  parameter int unsigned OUT_REGS   = 0,
  parameter int unsigned RDW_MODE   = 0
) (
  input  logic                             Clk_CI,
  input  logic                             Rst_RBI,
  input  logic                             WrEn_SI,
  input  logic [ADDR_WIDTH-1:0]            WrAddr_DI,
  input  logic [DATA_WIDTH-1:0]            WrData_DI,
  input  logic [DATA_WIDTH/BYTE_WIDTH-1:0] WrBe_SI,
  input  logic                             RdEn_SI,
  input  logic [ADDR_WIDTH-1:0]            RdAddr_DI,
  output logic [DATA_WIDTH-1:0]            RdData_DO,
  output logic                             RdValid_SO
);
  localparam int unsigned NUM_BYTES = DATA_WIDTH / BYTE_WIDTH;
  localparam logic [ADDR_WIDTH:0] DEPTH_W = (ADDR_WIDTH + 1)'(DATA_DEPTH);

  sync_tp_ram_be_chk #(
    .ADDR_WIDTH(ADDR_WIDTH), .DATA_DEPTH(DATA_DEPTH), .DATA_WIDTH(DATA_WIDTH),
    .BYTE_WIDTH(BYTE_WIDTH), .OUT_REGS(OUT_REGS)
  ) u_chk ();

  logic [DATA_WIDTH-1:0] r_mem [DATA_DEPTH];

  logic                  w_wr_in_range;
  logic                  w_rd_in_range;
  logic                  w_hit;
  logic [DATA_WIDTH-1:0] r_d0;
  logic                  r_v0;
  logic                  r_hit;
  logic [DATA_WIDTH-1:0] r_wdata;
  logic [NUM_BYTES-1:0]  r_wbe;
  logic [DATA_WIDTH-1:0] w_d0;

  assign w_wr_in_range = ({1'b0, WrAddr_DI} < DEPTH_W);
  assign w_rd_in_range = ({1'b0, RdAddr_DI} < DEPTH_W);
  // Only write-first mode ever flags a collision; read-first just returns the old word.
  assign w_hit = (RDW_MODE == 1) && WrEn_SI && RdEn_SI && w_rd_in_range &&
                 (WrAddr_DI == RdAddr_DI);

  // Byte-lane writes into the array; the array itself is never reset.
  always_ff @(posedge Clk_CI) begin
    if (Rst_RBI && WrEn_SI && w_wr_in_range) begin
      for (int i = 0; i < NUM_BYTES; i++) begin
        if (WrBe_SI[i]) begin
          r_mem[WrAddr_DI][i*BYTE_WIDTH +: BYTE_WIDTH] <= WrData_DI[i*BYTE_WIDTH +: BYTE_WIDTH];
        end
      end
    end
  end

  // RAM output register plus the collision side-band captured alongside each read.
  always_ff @(posedge Clk_CI or negedge Rst_RBI) begin
    if (!Rst_RBI) begin
      r_d0    <= '0;
      r_v0    <= 1'b0;
      r_hit   <= 1'b0;
      r_wdata <= '0;
      r_wbe   <= '0;
    end else begin
      r_v0 <= RdEn_SI;
      if (RdEn_SI) begin
        r_d0    <= w_rd_in_range ? r_mem[RdAddr_DI] : '0;
        r_hit   <= w_hit;
        r_wdata <= WrData_DI;
        r_wbe   <= WrBe_SI;
      end
    end
  end

  // Write-first merge applied after the RAM register so the array stays read-first.
  always_comb begin
    w_d0 = r_d0;
    for (int i = 0; i < NUM_BYTES; i++) begin
      if (r_hit && r_wbe[i]) begin
        w_d0[i*BYTE_WIDTH +: BYTE_WIDTH] = r_wdata[i*BYTE_WIDTH +: BYTE_WIDTH];
      end else begin
        w_d0[i*BYTE_WIDTH +: BYTE_WIDTH] = r_d0[i*BYTE_WIDTH +: BYTE_WIDTH];
      end
    end
  end

  logic [DATA_WIDTH-1:0] w_pd [OUT_REGS+1];
  logic                  w_pv [OUT_REGS+1];

  assign w_pd[0] = w_d0;
  assign w_pv[0] = r_v0;

  for (genvar k = 1; k <= OUT_REGS; k++) begin : g_pipe
    logic [DATA_WIDTH-1:0] r_d;
    logic                  r_v;

    // Stage data loads only on a valid result so the output holds between reads.
    always_ff @(posedge Clk_CI or negedge Rst_RBI) begin
      if (!Rst_RBI) begin
        r_d <= '0;
        r_v <= 1'b0;
      end else begin
        r_v <= w_pv[k-1];
        if (w_pv[k-1]) begin
          r_d <= w_pd[k-1];
        end
      end
    end

    assign w_pd[k] = r_d;
    assign w_pv[k] = r_v;
  end

  assign RdData_DO  = w_pd[OUT_REGS];
  assign RdValid_SO = w_pv[OUT_REGS];
endmodule
